// File: rtl/qed_pkg.sv
// Shared types and constants for the QED consistency checker.
package qed_pkg;

  // A duplicate writes to the original register index plus this offset.
  localparam int unsigned QED_DUP_OFFSET = 16;

  // One buffered original writeback.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } qed_entry_t;

  // Register index the duplicate of an original write to rd is expected to use.
  function automatic logic [4:0] dup_rd(input logic [4:0] rd);
    return rd + 5'(QED_DUP_OFFSET);
  endfunction

endpackage

// File: rtl/qed_result_fifo.sv
// Buffers original writeback results until their duplicates arrive.
// The head entry is visible on rdata_o whenever the FIFO is not empty.
module qed_result_fifo
  import qed_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  qed_entry_t wdata_i,
  output qed_entry_t rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       empty_nxt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  qed_entry_t  mem_q [DEPTH];
  logic        do_push, do_pop;

  // Status flags and next pointer values; the extra MSB tells full from empty.
  always_comb begin
    full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    empty_o = (wr_ptr_q == rd_ptr_q);
    do_push = push_i && !full_o && !clear_i;
    do_pop  = pop_i && !empty_o && !clear_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end
    empty_nxt_o = (wr_ptr_d == rd_ptr_d);
    rdata_o     = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/qed_consistency_checker.sv
// Compares each duplicate writeback against its buffered original and
// tracks commit counts, a ready indication and sticky error/mismatch flags.
module qed_consistency_checker
  import qed_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DUP_OFFSET = QED_DUP_OFFSET
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic             wb_is_dup,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic [CNT_W-1:0] qed_num_orig,
  output logic [CNT_W-1:0] qed_num_dup,
  output logic             qed_ready,
  output logic             qed_mismatch,
  output logic             qed_error,
  output logic [4:0]       mismatch_rd,
  output logic [31:0]      mismatch_orig,
  output logic [31:0]      mismatch_dup
);

  localparam logic [4:0]       DupOff = 5'(DUP_OFFSET);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] num_orig_q, num_orig_d;
  logic [CNT_W-1:0] num_dup_q, num_dup_d;
  logic             ready_q, ready_d;
  logic             mismatch_q, mismatch_d;
  logic             error_q, error_d;
  logic [4:0]       mm_rd_q, mm_rd_d;
  logic [31:0]      mm_orig_q, mm_orig_d;
  logic [31:0]      mm_dup_q, mm_dup_d;

  logic       orig_evt, dup_evt, fifo_push, fifo_pop, cmp_bad;
  logic       fifo_full, fifo_empty, fifo_empty_nxt;
  qed_entry_t fifo_wdata, fifo_head;

  // Writebacks to x0 are architecturally invisible and are filtered out.
  always_comb begin
    orig_evt   = wb_valid && (wb_rd != 5'd0) && !wb_is_dup && !flush;
    dup_evt    = wb_valid && (wb_rd != 5'd0) && wb_is_dup && !flush;
    fifo_push  = orig_evt && !fifo_full;
    fifo_pop   = dup_evt && !fifo_empty;
    fifo_wdata = '{rd: wb_rd, data: wb_data};
    cmp_bad    = fifo_pop && ((wb_rd != (fifo_head.rd + DupOff)) ||
                              (wb_data != fifo_head.data));
  end

  qed_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (flush),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .wdata_i     (fifo_wdata),
    .rdata_o     (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .empty_nxt_o (fifo_empty_nxt)
  );

  // Next-state for counters, sticky flags, first-mismatch capture and ready.
  always_comb begin
    num_orig_d = num_orig_q;
    num_dup_d  = num_dup_q;
    mismatch_d = mismatch_q;
    error_d    = error_q;
    mm_rd_d    = mm_rd_q;
    mm_orig_d  = mm_orig_q;
    mm_dup_d   = mm_dup_q;
    if (flush) begin
      num_orig_d = '0;
      num_dup_d  = '0;
      mismatch_d = 1'b0;
      error_d    = 1'b0;
      mm_rd_d    = '0;
      mm_orig_d  = '0;
      mm_dup_d   = '0;
    end else begin
      if (orig_evt && (num_orig_q != CntMax)) num_orig_d = num_orig_q + CntOne;
      if (dup_evt && (num_dup_q != CntMax))   num_dup_d  = num_dup_q + CntOne;
      if ((orig_evt && fifo_full) || (dup_evt && fifo_empty)) error_d = 1'b1;
      if (cmp_bad) begin
        mismatch_d = 1'b1;
        // Only the first mismatch is recorded; later ones keep the capture.
        if (!mismatch_q) begin
          mm_rd_d   = fifo_head.rd;
          mm_orig_d = fifo_head.data;
          mm_dup_d  = wb_data;
        end
      end
    end
    // Ready reflects the state that becomes visible next cycle.
    ready_d = !flush && (num_orig_d == num_dup_d) && (num_orig_d != '0) &&
              fifo_empty_nxt && !mismatch_d && !error_d;
  end

  // Output state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_orig_q <= '0;
      num_dup_q  <= '0;
      ready_q    <= 1'b0;
      mismatch_q <= 1'b0;
      error_q    <= 1'b0;
      mm_rd_q    <= '0;
      mm_orig_q  <= '0;
      mm_dup_q   <= '0;
    end else begin
      num_orig_q <= num_orig_d;
      num_dup_q  <= num_dup_d;
      ready_q    <= ready_d;
      mismatch_q <= mismatch_d;
      error_q    <= error_d;
      mm_rd_q    <= mm_rd_d;
      mm_orig_q  <= mm_orig_d;
      mm_dup_q   <= mm_dup_d;
    end
  end

  assign qed_num_orig  = num_orig_q;
  assign qed_num_dup   = num_dup_q;
  assign qed_ready     = ready_q;
  assign qed_mismatch  = mismatch_q;
  assign qed_error     = error_q;
  assign mismatch_rd   = mm_rd_q;
  assign mismatch_orig = mm_orig_q;
  assign mismatch_dup  = mm_dup_q;

endmodule

// File: tb/tb_qed_consistency_checker.sv
// Directed and randomized bench for qed_consistency_checker against a
// queue-based reference model.
module tb_qed_consistency_checker;
  import qed_pkg::*;

  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int CNTMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, flush, wb_valid, wb_is_dup;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [CNT_W-1:0] qed_num_orig, qed_num_dup;
  logic             qed_ready, qed_mismatch, qed_error;
  logic [4:0]       mismatch_rd;
  logic [31:0]      mismatch_orig, mismatch_dup;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  qed_entry_t  mq[$];
  int          m_orig, m_dup;
  bit          m_mm, m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_od, m_dd;

  qed_consistency_checker #(
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W),
    .DUP_OFFSET (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .wb_valid      (wb_valid),
    .wb_is_dup     (wb_is_dup),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .qed_num_orig  (qed_num_orig),
    .qed_num_dup   (qed_num_dup),
    .qed_ready     (qed_ready),
    .qed_mismatch  (qed_mismatch),
    .qed_error     (qed_error),
    .mismatch_rd   (mismatch_rd),
    .mismatch_orig (mismatch_orig),
    .mismatch_dup  (mismatch_dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_orig = 0;
    m_dup  = 0;
    m_mm   = 0;
    m_err  = 0;
    m_rd   = '0;
    m_od   = '0;
    m_dd   = '0;
  endtask

  task automatic model_wb(input bit dup, input logic [4:0] rd, input logic [31:0] data);
    qed_entry_t e;
    logic [4:0] want_rd;
    if (rd == 5'd0) return;
    if (!dup) begin
      if (mq.size() < DEPTH) mq.push_back('{rd: rd, data: data});
      else m_err = 1;
      if (m_orig < CNTMAX) m_orig++;
    end else begin
      if (m_dup < CNTMAX) m_dup++;
      if (mq.size() == 0) begin
        m_err = 1;
      end else begin
        e = mq.pop_front();
        want_rd = 5'((int'(e.rd) + 16) % 32);
        if (rd != want_rd || data != e.data) begin
          if (!m_mm) begin
            m_rd = e.rd;
            m_od = e.data;
            m_dd = data;
          end
          m_mm = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string pfx);
    bit exp_ready;
    exp_ready = (m_orig == m_dup) && (m_orig != 0) && (mq.size() == 0) && !m_mm && !m_err;
    chk({pfx, ".num_orig"}, 32'(qed_num_orig), 32'(m_orig));
    chk({pfx, ".num_dup"}, 32'(qed_num_dup), 32'(m_dup));
    chk({pfx, ".ready"}, 32'(qed_ready), 32'(exp_ready));
    chk({pfx, ".mismatch"}, 32'(qed_mismatch), 32'(m_mm));
    chk({pfx, ".error"}, 32'(qed_error), 32'(m_err));
    chk({pfx, ".mm_rd"}, 32'(mismatch_rd), 32'(m_rd));
    chk({pfx, ".mm_orig"}, mismatch_orig, m_od);
    chk({pfx, ".mm_dup"}, mismatch_dup, m_dd);
  endtask

  // Apply one writeback for one cycle, then compare just after the edge.
  task automatic wb(input string tag, input bit dup, input logic [4:0] rd,
                    input logic [31:0] data);
    wb_valid  = 1'b1;
    wb_is_dup = dup;
    wb_rd     = rd;
    wb_data   = data;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    model_wb(dup, rd, data);
    check_all(tag);
  endtask

  task automatic do_flush(input string tag);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_reset();
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    wb_rd   = 5'($urandom_range(0, 31));
    wb_data = $urandom;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    int r;
    logic [4:0] rd;
    logic [31:0] d;
    rst = 1'b1;
    flush = 1'b0;
    wb_valid = 1'b0;
    wb_is_dup = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Matching pair after reset.
    wb("pair.orig", 1'b0, 5'd3, 32'h1234);
    wb("pair.dup", 1'b1, 5'd19, 32'h1234);
    chk("pair.ready_hi", 32'(qed_ready), 32'd1);
    wb("pair.push_drops_ready", 1'b0, 5'd4, 32'h55);
    wb("pair.dup2", 1'b1, 5'd20, 32'h55);

    // Value mismatch; second mismatch must not overwrite capture.
    do_flush("vmm.flush");
    wb("vmm.orig", 1'b0, 5'd5, 32'hA);
    wb("vmm.dup", 1'b1, 5'd21, 32'hB);
    chk("vmm.rd", 32'(mismatch_rd), 32'd5);
    chk("vmm.dupdata", mismatch_dup, 32'hB);
    wb("vmm.orig2", 1'b0, 5'd6, 32'h1);
    wb("vmm.dup2", 1'b1, 5'd22, 32'h2);

    // Register mismatch.
    do_flush("rmm.flush");
    wb("rmm.orig", 1'b0, 5'd2, 32'h7);
    wb("rmm.dup", 1'b1, 5'd20, 32'h7);
    chk("rmm.flag", 32'(qed_mismatch), 32'd1);

    // Overflow: nine originals, then drain the eight that were kept.
    do_flush("ovf.flush");
    for (int i = 1; i <= 9; i++) wb("ovf.orig", 1'b0, 5'(i), 32'(100 + i));
    chk("ovf.error", 32'(qed_error), 32'd1);
    for (int i = 1; i <= 8; i++) wb("ovf.drain", 1'b1, 5'(i + 16), 32'(100 + i));
    chk("ovf.no_mm", 32'(qed_mismatch), 32'd0);

    // Underflow.
    do_flush("udf.flush");
    wb("udf.dup", 1'b1, 5'd17, 32'h9);

    // x0 filtering and flush with a partly filled FIFO.
    do_flush("x0.flush");
    wb("x0.orig", 1'b0, 5'd0, 32'hDEAD);
    wb("x0.dup", 1'b1, 5'd0, 32'hBEEF);
    for (int i = 1; i <= 3; i++) wb("fl.orig", 1'b0, 5'(i), 32'(i));
    do_flush("fl.flush");
    wb("fl.after", 1'b1, 5'd17, 32'd1);

    // Asynchronous reset between clock edges.
    do_flush("ar.flush");
    wb("ar.orig", 1'b0, 5'd7, 32'h77);
    wb("ar.orig2", 1'b0, 5'd8, 32'h88);
    wb("ar.dup", 1'b1, 5'd1, 32'h0);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("ar.async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    wb("ar.post", 1'b1, 5'd23, 32'h77);

    // Randomized traffic.
    do_flush("rnd.flush");
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_flush("rnd.flush");
      end else if (r < 48) begin
        wb("rnd.orig", 1'b0, 5'($urandom_range(0, 15)), $urandom);
      end else if (r < 90) begin
        if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
          rd = 5'((int'(mq[0].rd) + 16) % 32);
          d  = mq[0].data;
        end else begin
          rd = 5'($urandom_range(0, 31));
          d  = $urandom_range(0, 3);
        end
        wb("rnd.dup", 1'b1, rd, d);
      end else begin
        idle("rnd.idle");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
